// File: rtl/operand_entry_sequencer_if.sv
// Board-side inputs and ALU-side outputs of the operand entry sequencer.
// The master modport drives the raw pins; the slave modport is the sequencer itself.
interface operand_entry_sequencer_if #(
    parameter int DataLength = 4
);
    logic                  button;
    logic [DataLength-1:0] switchSet;
    logic                  carryInSwitch;
    logic [DataLength-1:0] operandA;
    logic [DataLength-1:0] operandB;
    logic [3:0]            ALUControl;
    logic                  carryIn;
    logic                  operandsValid;
    logic [1:0]            entryState;
    logic                  pressPulse;

    modport master (
        output button, switchSet, carryInSwitch,
        input  operandA, operandB, ALUControl, carryIn, operandsValid, entryState, pressPulse
    );

    modport slave (
        input  button, switchSet, carryInSwitch,
        output operandA, operandB, ALUControl, carryIn, operandsValid, entryState, pressPulse
    );
endinterface

// File: rtl/operand_entry_sequencer.sv
// Synchronises and debounces the entry button, then latches operand A, operand B
// and the ALU select on successive presses before flagging them valid.
module operand_entry_sequencer #(
    parameter int DataLength     = 4,
    parameter int DebounceCycles = 500000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    operand_entry_sequencer_if.slave     bus
);
    localparam int CntW = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;

    typedef enum logic [1:0] {
        LOAD_A   = 2'd0,
        LOAD_B   = 2'd1,
        LOAD_SEL = 2'd2,
        DONE     = 2'd3
    } entry_state_e;

    logic                  btn_meta_q, btn_sync_q;
    logic [DataLength-1:0] sw_meta_q, sw_sync_q;
    logic                  cin_meta_q, cin_sync_q, carry_q;
    logic [1:0]            sync_vld_q;
    logic                  armed_q, armed_d;
    logic                  stable_q, stable_d, stable_dly_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  fall_s;
    entry_state_e          state_q, state_d;
    logic [DataLength-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [3:0]            sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic                  pulse_q;

    // Two-flop synchronisers for every raw pin, plus the registered carry copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            sw_meta_q  <= {DataLength{1'b0}};
            sw_sync_q  <= {DataLength{1'b0}};
            cin_meta_q <= 1'b0;
            cin_sync_q <= 1'b0;
            carry_q    <= 1'b0;
            sync_vld_q <= 2'b00;
        end else begin
            btn_meta_q <= bus.button;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.switchSet;
            sw_sync_q  <= sw_meta_q;
            cin_meta_q <= bus.carryInSwitch;
            cin_sync_q <= cin_meta_q;
            carry_q    <= cin_sync_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // Debounce counter and stable-level update
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (btn_sync_q == stable_q) begin
            cnt_d = {CntW{1'b0}};
        end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
            stable_d = btn_sync_q;
            cnt_d    = {CntW{1'b0}};
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Presses are only honoured once a genuine released level has been seen
    // after reset, so a button held low across reset cannot fire.
    assign armed_d = armed_q | (sync_vld_q[1] & btn_sync_q & stable_q);
    assign fall_s  = stable_dly_q & ~stable_q & armed_q;

    // Debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= {CntW{1'b0}};
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            armed_q      <= armed_d;
        end
    end

    // Entry FSM next state and capture values
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (fall_s) begin
            case (state_q)
                LOAD_A: begin
                    opa_d   = sw_sync_q;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    opb_d   = sw_sync_q;
                    state_d = LOAD_SEL;
                end
                LOAD_SEL: begin
                    sel_d   = sw_sync_q[3:0];
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Entry FSM state, captured operands and press pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD_A;
            opa_q   <= {DataLength{1'b0}};
            opb_q   <= {DataLength{1'b0}};
            sel_q   <= 4'h0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            pulse_q <= fall_s;
        end
    end

    assign bus.operandA      = opa_q;
    assign bus.operandB      = opb_q;
    assign bus.ALUControl    = sel_q;
    assign bus.carryIn       = carry_q;
    assign bus.operandsValid = valid_q;
    assign bus.entryState    = state_q;
    assign bus.pressPulse    = pulse_q;
endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Scoreboard bench: each press pushes its expected post-capture outputs; a monitor
// pops and compares whenever pressPulse is seen.
module tb_operand_entry_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int unsigned cyc = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        int unsigned cyc;
        bit          lat_chk;
        logic [1:0]  st;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  sel;
        logic        v;
    } exp_t;
    exp_t exp_q[$];

    operand_entry_sequencer_if #(.DataLength(4)) bus ();

    operand_entry_sequencer #(.DataLength(4), .DebounceCycles(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: set switches, press, hold, release; expect one pulse 7 cycles later
    task automatic press(input logic [3:0] sw, input logic [1:0] st, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] sel, input logic v);
        exp_t e;
        @(negedge clk);
        bus.switchSet = sw;
        tick(4);
        e.cyc = cyc; e.lat_chk = 1'b1;
        e.st = st; e.a = a; e.b = b; e.sel = sel; e.v = v;
        exp_q.push_back(e);
        bus.button = 1'b0;
        tick(15);
        bus.button = 1'b1;
        tick(15);
        check("pulse_arrived", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_opA"},   bus.operandA, 0);
        check({tag, "_opB"},   bus.operandB, 0);
        check({tag, "_sel"},   bus.ALUControl, 0);
        check({tag, "_cin"},   bus.carryIn, 0);
        check({tag, "_valid"}, bus.operandsValid, 0);
        check({tag, "_state"}, bus.entryState, 0);
        check({tag, "_pulse"}, bus.pressPulse, 0);
    endtask

    // Monitor: every observed pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset_n && bus.pressPulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.lat_chk) check("pulse_latency", cyc - e.cyc, 7);
                check("state", bus.entryState, e.st);
                check("opA", bus.operandA, e.a);
                check("opB", bus.operandB, e.b);
                check("sel", bus.ALUControl, e.sel);
                check("valid", bus.operandsValid, e.v);
            end
        end
    end

    initial begin
        exp_t e;
        bus.button = 1'b1;
        bus.switchSet = 4'h0;
        bus.carryInSwitch = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(6);

        // Glitch of 3 cycles must be rejected
        bus.button = 1'b0;
        tick(3);
        bus.button = 1'b1;
        tick(20);
        check("reject_state", bus.entryState, 0);

        // Full entry
        press(4'h5, 2'd1, 4'h5, 4'h0, 4'h0, 1'b0);
        press(4'h3, 2'd2, 4'h5, 4'h3, 4'h0, 1'b0);
        press(4'h2, 2'd3, 4'h5, 4'h3, 4'h2, 1'b1);

        // Switch isolation in DONE
        for (int i = 0; i < 16; i++) begin
            bus.switchSet = 4'(i);
            tick(2);
            check("iso_opA", bus.operandA, 4'h5);
            check("iso_opB", bus.operandB, 4'h3);
            check("iso_sel", bus.ALUControl, 4'h2);
        end
        check("iso_state", bus.entryState, 3);
        bus.carryInSwitch = 1'b1;
        tick(2);
        check("cin_2cyc", bus.carryIn, 0);
        tick(1);
        check("cin_3cyc", bus.carryIn, 1);

        // Wrap with bouncy held press: exactly one pulse
        e.cyc = 0; e.lat_chk = 1'b0;
        e.st = 2'd0; e.a = 4'h5; e.b = 4'h3; e.sel = 4'h2; e.v = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            bus.button = 1'b0;
            tick(2);
            bus.button = 1'b1;
            tick(2);
        end
        bus.button = 1'b0;
        tick(100);
        bus.button = 1'b1;
        tick(20);
        check("bounce_pulse_arrived", exp_q.size(), 0);
        exp_q.delete();
        check("wrap_state", bus.entryState, 0);
        check("wrap_valid", bus.operandsValid, 0);
        check("wrap_opA", bus.operandA, 4'h5);

        press(4'h9, 2'd1, 4'h9, 4'h3, 4'h2, 1'b0);
        press(4'h4, 2'd2, 4'h9, 4'h4, 4'h2, 1'b0);

        // Reset while the button is held in LOAD_SEL
        bus.button = 1'b0;
        tick(3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(3);
        reset_n = 1'b1;
        tick(30);
        check("held_state", bus.entryState, 0);
        check("held_opA", bus.operandA, 0);
        bus.button = 1'b1;
        tick(20);
        press(4'h7, 2'd1, 4'h7, 4'h0, 4'h0, 1'b0);

        tick(5);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
